ysyx_22051468_scoreboard: RTL and testbench
===========================================

YSYX_22051468_SCOREBOARD -- requirements
Module: ysyx_22051468_Scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of issued-but-not-written-back instructions with rd_need=1.
REQ-002 SHALL have parameter CNT_W, default 2, meaning the width of each per-register pending counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port id_valid, input, 1, the decode stage presents an instruction.
REQ-006 SHALL have port id_ready, output, 1, the scoreboard accepts the instruction this cycle.
REQ-007 SHALL have ports rd_need, rs1_need and rs2_need, each input, 1, operand-need flags from the Rs/Imm need decoder.
REQ-008 SHALL have ports rd_addr, rs1_addr and rs2_addr, each input, 5, register indices.
REQ-009 SHALL have port wb_valid, input, 1, a writeback retires one rd this cycle.
REQ-010 SHALL have port wb_rd, input, 5, the retiring register index.
REQ-011 SHALL have port flush, input, 1, a synchronous flush that discards all pending writes.
REQ-012 SHALL have port stall, output, 1, equal to id_valid & ~id_ready.
REQ-013 SHALL have port inflight_cnt, output, $clog2(MAX_INFLIGHT+1), the registered count of outstanding writes.

Function
REQ-014 SHALL define issue = id_valid & id_ready.
REQ-015 SHALL keep a CNT_W-bit pending counter pend[r] for each r in 1..31, with pend[0] hardwired to 0.
REQ-016 SHALL treat rs1 as hazardous when rs1_need=1, rs1_addr!=0 and eff(rs1_addr)!=0.
- eff(r) = pend[r] - (wb_valid & wb_rd==r & pend[r]!=0).
- This bypasses a same-cycle writeback.
REQ-017 SHALL apply the rs1 hazard rule to rs2 identically.
REQ-018 SHALL flag a WAW-saturation hazard when rd_need=1, rd_addr!=0 and eff(rd_addr)==2^CNT_W-1.
REQ-019 SHALL flag a capacity hazard when rd_need=1 and the effective inflight count equals MAX_INFLIGHT.
- Effective inflight = inflight_cnt - (a wb that decrements this cycle).
REQ-020 SHALL drive id_ready = ~flush & ~(rs1 hazard | rs2 hazard | WAW hazard | capacity hazard).
REQ-021 SHALL compute id_ready combinationally from state and current inputs, with zero-cycle latency.
REQ-022 SHALL ensure id_ready does not depend on id_valid.
REQ-023 SHALL, on issue with rd_need=1 and rd_addr!=0, increment pend[rd_addr] and inflight_cnt on the next edge.
REQ-024 SHALL, on wb_valid with pend[wb_rd]!=0 and wb_rd!=0, decrement pend[wb_rd] and inflight_cnt.
REQ-025 SHALL ignore a wb_valid where wb_rd==0 or pend[wb_rd]==0, with no underflow.
REQ-026 SHALL leave pend[r] and inflight_cnt unchanged when issue and wb target the same r in one cycle.
REQ-027 SHALL apply an issue and a wb to different registers in the same cycle independently, with net inflight change 0.
REQ-028 SHALL never change state on an instruction with rd_need=0, or with rd_addr=0.
REQ-029 SHALL give flush priority over every other input.
- On the next edge all pend[] and inflight_cnt become 0.
- Issue and wb in the flush cycle are discarded.
REQ-030 SHALL ensure that with no wb activity inflight_cnt never exceeds MAX_INFLIGHT and no pend[r] overflows.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force all pend[] to 0 and inflight_cnt to 0.
- id_ready then equals ~flush, with no hazard possible.
REQ-032 SHALL make the deassertion of rst_n take effect at the first rising clk edge that follows it.
REQ-033 SHALL, on reset asserted mid-operation, lose all outstanding state immediately, with no pending write surviving.

Structure
REQ-034 SHALL place in the shared INST_TYPE package/header:
- the register-index width (5);
- the x0 index;
- MAX_INFLIGHT default.
REQ-035 SHALL implement per-register counter logic (inc/dec/hold/clear) as one sub-module ysyx_22051468_Pend_Cnt, instantiated 31 times.
REQ-036 SHALL perform the hazard compare and the inflight counter in the top module.

Verification
REQ-037 SHALL cover RAW stall and bypass: issue rd=5, then present rs1=5 with rs1_need=1.
- Required: stall=1 until wb_rd=5.
- In the wb cycle, id_ready=1 via bypass.
- pend[5]=0 after.
REQ-038 SHALL cover x0: issue rd=0, then rs1=0 and rs2=0 with needs set.
- Required: id_ready=1 always.
- inflight_cnt stays 0.
REQ-039 SHALL cover capacity: issue 4 distinct rd (1,2,3,4) with no wb, then a fifth rd=6.
- Required: inflight_cnt=4 and id_ready=0.
- With wb_rd=1 in the same cycle: id_ready=1, inflight stays 4.
REQ-040 SHALL cover WAW saturation: issue rd=7 three times, then a fourth issue to rd=7.
- Required: the fourth is stalled until one wb_rd=7.
REQ-041 SHALL cover simultaneous issue and wb to the same register: pend[9]=1, issue rd=9 while wb_rd=9.
- Required: pend[9]=1 and inflight_cnt unchanged.
REQ-042 SHALL cover flush and reset: flush with 3 outstanding while issue and wb are both active.
- Required: all counts 0 the next cycle and id_ready=0 in the flush cycle.
- Repeat with rst_n pulsed low between edges: outputs clear without a clock edge.

Source files
------------

// File: rtl/ysyx_22051468_scoreboard_pkg.sv
// Shared instruction-field constants for the issue scoreboard.
package ysyx_22051468_scoreboard_pkg;
   localparam int          REG_AW           = 5;
   localparam int          NUM_REGS         = 32;
   localparam logic [4:0]  REG_X0           = 5'd0;
   localparam int          MAX_INFLIGHT_DEF = 4;
   localparam int          CNT_W_DEF        = 2;
endpackage

// File: rtl/ysyx_22051468_scoreboard_pend_cnt.sv
// Per-register pending-write counter: clear beats everything, inc+dec together hold.
module ysyx_22051468_Pend_Cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !dec_i)
         cnt_d = cnt_q + CNT_W'(1);
      else if (dec_i && !inc_i)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/ysyx_22051468_scoreboard.sv
// In-order issue scoreboard: RAW/WAW/capacity hazard detection with same-cycle
// writeback bypass, plus the outstanding-write counter.
module ysyx_22051468_scoreboard
   import ysyx_22051468_scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic              rd_need,
   input  logic              rs1_need,
   input  logic              rs2_need,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              flush,
   output logic              stall,
   output logic [IW-1:0]     inflight_cnt
);
   logic [CNT_W-1:0] pend [NUM_REGS];
   logic [IW-1:0]    inflight_q, inflight_d;

   logic             issue, issue_inc, wb_dec;
   logic [CNT_W-1:0] rs1_pend, rs2_pend, rd_pend;
   logic [CNT_W-1:0] rs1_eff, rs2_eff, rd_eff;
   logic             rs1_haz, rs2_haz, waw_haz, cap_haz;
   logic [IW-1:0]    inflight_eff;

   assign pend[0] = '0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
      ysyx_22051468_Pend_Cnt #(.CNT_W(CNT_W)) u_pend (
         .clk   (clk),
         .rst_n (rst_n),
         .clr_i (flush),
         .inc_i (issue_inc && (rd_addr == REG_AW'(r))),
         .dec_i (wb_dec && (wb_rd == REG_AW'(r))),
         .cnt_o (pend[r])
      );
   end

   assign wb_dec = wb_valid && (wb_rd != REG_X0) && (pend[wb_rd] != '0);

   // Effective counts subtract a writeback landing this cycle, so a retiring
   // producer releases its consumer with zero bubble.
   assign rs1_pend = pend[rs1_addr];
   assign rs2_pend = pend[rs2_addr];
   assign rd_pend  = pend[rd_addr];
   assign rs1_eff  = rs1_pend - CNT_W'(wb_dec && (wb_rd == rs1_addr));
   assign rs2_eff  = rs2_pend - CNT_W'(wb_dec && (wb_rd == rs2_addr));
   assign rd_eff   = rd_pend  - CNT_W'(wb_dec && (wb_rd == rd_addr));

   assign rs1_haz  = rs1_need && (rs1_addr != REG_X0) && (rs1_eff != '0);
   assign rs2_haz  = rs2_need && (rs2_addr != REG_X0) && (rs2_eff != '0);
   assign waw_haz  = rd_need && (rd_addr != REG_X0) && (rd_eff == {CNT_W{1'b1}});

   assign inflight_eff = inflight_q - IW'(wb_dec);
   assign cap_haz      = rd_need && (inflight_eff == IW'(MAX_INFLIGHT));

   assign id_ready  = !flush && !(rs1_haz || rs2_haz || waw_haz || cap_haz);
   assign stall     = id_valid && !id_ready;
   assign issue     = id_valid && id_ready;
   assign issue_inc = issue && rd_need && (rd_addr != REG_X0);

   always_comb begin
      inflight_d = inflight_q + IW'(issue_inc) - IW'(wb_dec);
      if (flush)
         inflight_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         inflight_q <= '0;
      else
         inflight_q <= inflight_d;
   end

   assign inflight_cnt = inflight_q;
endmodule

// File: tb/tb_ysyx_22051468_scoreboard.sv
// Directed checks of scoreboard hazards, bypass, capacity, flush and reset.
module tb_ysyx_22051468_scoreboard;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_ready;
   logic       rd_need, rs1_need, rs2_need;
   logic [4:0] rd_addr, rs1_addr, rs2_addr;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       flush, stall;
   logic [2:0] inflight_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_22051468_scoreboard dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .rd_need      (rd_need),
      .rs1_need     (rs1_need),
      .rs2_need     (rs2_need),
      .rd_addr      (rd_addr),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .flush        (flush),
      .stall        (stall),
      .inflight_cnt (inflight_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; rd_need = 0; rs1_need = 0; rs2_need = 0;
      rd_addr = 0; rs1_addr = 0; rs2_addr = 0;
      wb_valid = 0; wb_rd = 0; flush = 0;
   endtask

   // Advance one edge; inputs are then changed and sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_rd(input logic [4:0] r);
      idle(); id_valid = 1; rd_need = 1; rd_addr = r;
   endtask

   task automatic read_rs1(input logic [4:0] r);
      idle(); id_valid = 1; rs1_need = 1; rs1_addr = r;
   endtask

   task automatic wb(input logic [4:0] r);
      idle(); wb_valid = 1; wb_rd = r;
   endtask

   initial begin
      idle();
      rst_n = 0;
      #2;
      chk("rst_inflight", inflight_cnt, 0);
      chk("rst_ready", id_ready, 1);
      flush = 1; #1;
      chk("rst_ready_flush", id_ready, 0);
      flush = 0;
      step();
      rst_n = 1;
      step();

      // RAW stall then same-cycle writeback bypass
      issue_rd(5); #1;
      chk("raw_issue_ready", id_ready, 1);
      step();
      chk("raw_inflight1", inflight_cnt, 1);
      read_rs1(5); #1;
      chk("raw_stall", stall, 1);
      step();
      chk("raw_stall_hold", stall, 1);
      wb_valid = 1; wb_rd = 5; #1;
      chk("raw_bypass_ready", id_ready, 1);
      chk("raw_bypass_stall", stall, 0);
      step();
      read_rs1(5); #1;
      chk("raw_after_inflight", inflight_cnt, 0);
      chk("raw_after_ready", id_ready, 1);
      step();

      // x0 never tracked, never hazardous
      issue_rd(0); #1;
      chk("x0_issue_ready", id_ready, 1);
      step();
      chk("x0_inflight", inflight_cnt, 0);
      idle(); id_valid = 1; rs1_need = 1; rs2_need = 1; #1;
      chk("x0_read_ready", id_ready, 1);
      step();
      chk("x0_inflight2", inflight_cnt, 0);

      // Capacity limit
      for (int i = 1; i <= 4; i++) begin
         issue_rd(5'(i));
         step();
      end
      issue_rd(6); #1;
      chk("cap_inflight4", inflight_cnt, 4);
      chk("cap_ready", id_ready, 0);
      chk("cap_stall", stall, 1);
      wb_valid = 1; wb_rd = 1; #1;
      chk("cap_wb_ready", id_ready, 1);
      step();
      chk("cap_inflight_hold", inflight_cnt, 4);
      wb(10);
      step();
      chk("wb_unpending_ignored", inflight_cnt, 4);
      wb(2); step();
      wb(3); step();
      chk("cap_drain2", inflight_cnt, 2);
      wb(4); step();
      wb(6); step();
      idle(); #1;
      chk("cap_drain0", inflight_cnt, 0);

      // WAW saturation at 3 pending writes to x7
      for (int i = 0; i < 3; i++) begin
         issue_rd(7);
         step();
      end
      issue_rd(7); #1;
      chk("waw_inflight3", inflight_cnt, 3);
      chk("waw_ready", id_ready, 0);
      step();
      chk("waw_stall_hold", stall, 1);
      wb_valid = 1; wb_rd = 7; #1;
      chk("waw_wb_ready", id_ready, 1);
      step();
      issue_rd(7); #1;
      chk("waw_after_inflight", inflight_cnt, 3);
      chk("waw_after_ready", id_ready, 0);
      wb(7); step();
      wb(7); step();
      wb(7); step();
      idle(); #1;
      chk("waw_drain", inflight_cnt, 0);

      // Same-register issue and writeback hold the count
      issue_rd(9); step();
      issue_rd(9); wb_valid = 1; wb_rd = 9; #1;
      chk("same_ready", id_ready, 1);
      step();
      read_rs1(9); #1;
      chk("same_inflight", inflight_cnt, 1);
      chk("same_pend_still1", id_ready, 0);

      // Different registers in one cycle: net zero
      issue_rd(11); wb_valid = 1; wb_rd = 9; #1;
      step();
      read_rs1(9); #1;
      chk("diff_inflight", inflight_cnt, 1);
      chk("diff_rs9_free", id_ready, 1);
      read_rs1(11); #1;
      chk("diff_rs11_busy", id_ready, 0);

      // Flush with 3 outstanding while issue and wb are active
      issue_rd(12); step();
      issue_rd(13); step();
      issue_rd(14); wb_valid = 1; wb_rd = 11; flush = 1; #1;
      chk("flush_pre_inflight", inflight_cnt, 3);
      chk("flush_ready", id_ready, 0);
      step();
      read_rs1(14); #1;
      chk("flush_inflight", inflight_cnt, 0);
      chk("flush_rs14_free", id_ready, 1);
      read_rs1(12); #1;
      chk("flush_rs12_free", id_ready, 1);

      // Asynchronous reset between edges
      issue_rd(15); step();
      issue_rd(16); step();
      idle(); #1;
      chk("rst_mid_pre", inflight_cnt, 2);
      rst_n = 0; #1;
      chk("rst_mid_inflight", inflight_cnt, 0);
      read_rs1(15); #1;
      chk("rst_mid_rs15_free", id_ready, 1);
      rst_n = 1;
      step();
      read_rs1(16); #1;
      chk("rst_after_rs16_free", id_ready, 1);
      chk("rst_after_inflight", inflight_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
